// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divider helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_tx_state_t;

  // Clock cycles per serial bit; integer divide so the line runs slightly fast if inexact.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter for uart_tx: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each bit with tick_o.
module uart_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first serial output with start/stop bits.
// Define UART_TX_PARITY_EN to insert an even parity bit between D7 and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_ready,
  output logic                      tx_done,
  output logic                      tx
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      accept;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign tx_ready = (state_q == IDLE) && rst_n;
  assign accept   = tx_valid && tx_ready;

  uart_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q != IDLE),
    .clr_i (accept),
    .tick_o(bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          shift_d  = tx_data;
          idx_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx tracks state_q exactly.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_done = done_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; follows UART_TX_PARITY_EN for frame shape.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_err  = 0;
  logic [7:0] rx_q[$];

  uart_tx #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame bit b as it should appear on the line; par is the hand-computed parity.
  function automatic logic frame_bit(input logic [7:0] d, input logic par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return par;
`else
    if (par === 1'bx) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Present a byte and wait (bounded) until the DUT is ready to take it at the next edge.
  task automatic offer(input logic [7:0] d, input string tag);
    int w;
    w = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && w < 50) begin
      step();
      w++;
    end
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  // Follows one frame from the accept edge (cycle 1 = first cycle after it) to the tx_done cycle.
  task automatic run_frame(input logic [7:0] d, input logic par, input string tag,
                           input int inject, input bit hold, input logic [7:0] after_data);
    int done_n, done_at, rdy_n, b, ph;
    done_n = 0; done_at = 0; rdy_n = 0;
    for (int c = 1; c <= FRAME + 1; c++) begin
      step();
      if (c == 1) begin
        tx_data = after_data;
        if (!hold) tx_valid = 1'b0;
      end
      if (inject != 0 && c == inject) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (inject != 0 && c == inject + 1) tx_valid = 1'b0;
      if (c <= FRAME) begin
        b  = (c - 1) / CPB;
        ph = (c - 1) % CPB;
        if (ph == 0 || ph == CPB - 1)
          check($sformatf("%s_bit%0d_ph%0d", tag, b, ph), {31'd0, tx}, {31'd0, frame_bit(d, par, b)});
        if (tx_ready) rdy_n++;
      end
      if (tx_done) begin
        done_n++;
        done_at = c;
      end
    end
    check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    check({tag, "_idle_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_cycle"}, done_at, FRAME + 1);
    check({tag, "_ready_in_frame"}, rdy_n, 0);
    $display("[TB] %s byte=%02h done_at=%0d", tag, d, done_at);
  endtask

  // Independent line receiver: mid-bit sampling, checks start, parity and stop.
  initial begin : rx_model
    int   cnt, idx;
    bit   busy;
    logic [NB-1:0] bits;
    busy = 1'b0; cnt = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (tx == 1'b0) begin
          busy = 1'b1;
          cnt  = 1;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          idx = cnt / CPB;
          bits[idx] = tx;
          if (idx == NB - 1) begin
            busy = 1'b0;
            if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) rx_err++;
`ifdef UART_TX_PARITY_EN
            else if (bits[9] !== ^bits[8:1]) rx_err++;
`endif
            else rx_q.push_back(bits[8:1]);
          end
        end
      end
    end
  end

  initial begin
    int low_n, done_n, err0;
    logic [7:0] lb [4];
    logic [7:0] got;

    // Reset state
    repeat (3) step();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // 1: 0xA5, parity 0, done at cycle 177 (parity build)
    offer(8'hA5, "a5");
    run_frame(8'hA5, 1'b0, "a5", 0, 1'b0, 8'h5A);

    // 2: parity 1 and all-zero data
    offer(8'h07, "x07");
    run_frame(8'h07, 1'b1, "x07", 0, 1'b0, 8'hF8);
    offer(8'h00, "x00");
    run_frame(8'h00, 1'b0, "x00", 0, 1'b0, 8'hFF);

    // 3: back-to-back with tx_valid held; one idle cycle between frames
    offer(8'h55, "b2b_55");
    run_frame(8'h55, 1'b0, "b2b_55", 0, 1'b1, 8'hAA);
    run_frame(8'hAA, 1'b0, "b2b_aa", 0, 1'b0, 8'h00);

    // 4: tx_valid pulse mid-frame is ignored and not queued
    step();
    offer(8'h96, "ign");
    run_frame(8'h96, 1'b0, "ign", 40, 1'b0, 8'h11);
    low_n = 0; done_n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!tx) low_n++;
      if (tx_done) done_n++;
    end
    check("ign_no_extra_frame", low_n, 0);
    check("ign_no_extra_done", done_n, 0);

    // 5: reset during D3 aborts the frame
    offer(8'h00, "abort");
    done_n = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 1) tx_valid = 1'b0;
      if (tx_done) done_n++;
    end
    check("abort_d3_low", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    step();
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check("abort_done", {31'd0, tx_done}, 32'd0);
    check("abort_ready_in_rst", {31'd0, tx_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("abort_ready_after", {31'd0, tx_ready}, 32'd1);
    low_n = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (!tx) low_n++;
      if (tx_done) done_n++;
    end
    check("abort_no_resume", low_n, 0);
    check("abort_no_done", done_n, 0);
    $display("[TB] abort reset during D3 handled");

    // 6: loopback into the receiver model
    rx_q.delete();
    err0 = rx_err;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'h81;
    offer(8'h00, "lb0"); run_frame(8'h00, 1'b0, "lb0", 0, 1'b0, 8'h00);
    offer(8'hFF, "lb1"); run_frame(8'hFF, 1'b0, "lb1", 0, 1'b0, 8'hFF);
    offer(8'h5A, "lb2"); run_frame(8'h5A, 1'b0, "lb2", 0, 1'b0, 8'h5A);
    offer(8'h81, "lb3"); run_frame(8'h81, 1'b0, "lb3", 0, 1'b0, 8'h81);
    repeat (4) step();
    check("lb_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("lb_data%0d", i), {24'd0, got}, {24'd0, lb[i]});
      $display("[TB] loopback rx byte %0d = %02h", i, got);
    end
    check("lb_frame_errors", rx_err - err0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

- Serial transmitter for the UART path; the counterpart stage to `uart_rx`.
- Accepts a byte over a valid/ready handshake and serialises it on `tx`, LSB first.
- Frame, parity enabled: start (0), D0..D7, even parity bit (XOR of D7..D0), stop (1).
- Feeds the line that `uart_rx` samples; frames must be accepted by that receiver unmodified.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115_200: line bit rate.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD_RATE (integer divide): clk cycles per bit. Must be ≥ 2; elaboration error otherwise.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `tx_valid`, input, 1: `tx_data` holds a byte to send.
- `tx_data`, input, 8: byte to send; sampled only on accept.
- `tx_ready`, output, 1: block can accept a byte. High only in IDLE and only while rst_n=1.
- `tx_done`, output, 1: one-cycle pulse when a frame's stop bit has completed.
- `tx`, output, 1: serial line; idles high.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Accept: `tx_valid && tx_ready` at a rising edge.
  - `tx_data` is latched into an 8-bit shift register.
  - Parity (XOR of the 8 bits) is latched.
  - State moves to START; the bit counter clears.
- Per-bit timing: a bit-period counter of width $clog2(CLKS_PER_BIT) runs 0..CLKS_PER_BIT-1 in every non-IDLE state. The wrap is the "bit end" tick.
- Transitions on bit end:
  - START → DATA.
  - DATA → DATA after each of bits 0..6; the shift register shifts right and the 3-bit index increments.
  - DATA → PARITY after bit 7.
  - PARITY → STOP.
  - STOP → IDLE.
- `tx` is registered:
  - IDLE/STOP = 1.
  - START = 0.
  - DATA = shift register bit 0.
  - PARITY = latched parity.
- `tx_valid` outside IDLE is ignored and not queued. Changes on `tx_data` after accept have no effect.
- Reset values: state IDLE, `tx` = 1, `tx_done` = 0, `tx_ready` = 0 while rst_n=0. Counters and shift register clear to 0.
- Reset mid-frame: abort. `tx` = 1 on the next edge, no `tx_done`, and no partial frame resumes after reset release.

## Timing

- Accept at edge E: `tx` goes low at E+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is 11·CLKS_PER_BIT cycles (10·CLKS_PER_BIT with parity compiled out).
- `tx_done` is high for the single cycle after the STOP bit-end edge. That is also the first IDLE cycle, with `tx_ready` = 1.
- Back-to-back: a byte accepted in that cycle starts its START bit on the next edge. Minimum gap between frames is therefore 1 clk of idle-high.
- `tx_ready` falls on the edge that accepts and stays low until the return to IDLE.

## Configuration

Macro `UART_TX_PARITY_EN`:
- Defined (project default; required for `uart_rx` compatibility): PARITY state present, even parity bit sent between D7 and stop.
- Undefined: PARITY state and parity register removed; DATA → STOP directly; frame is 10 bits.

## Structure

- Shared package `uart_pkg`:
  - State enum `uart_tx_state_t`.
  - `UART_DATA_BITS` = 8.
  - The `CLKS_PER_BIT` derivation function, reused by `uart_rx` configuration.
- One sub-module, `uart_tx_baud`: bit-period counter with an enable and a synchronous clear, producing the bit-end tick.
- All other logic lives in the `uart_tx` top.

## Test plan

Bench uses CLK_FREQ=1_600_000, BAUD_RATE=100_000, giving CLKS_PER_BIT=16.

1. Send 0xA5.
   - `tx` sequence, 16 cycles each: 0, 1,0,1,0,0,1,0,1, parity 0, 1.
   - `tx_done` pulses at cycle 177 after accept.
2. Send 0x07 → parity bit 1. Send 0x00 → parity bit 0 and data bits all 0.
3. Hold `tx_valid` high with 0x55 then 0xAA.
   - Two frames are separated by exactly 1 idle-high cycle.
   - `tx_ready` is high only in that cycle.
4. Pulse `tx_valid` with 0x3C at cycle 40 of a frame → ignored. Only the original frame is sent; `tx_done` pulses once.
5. Assert rst_n=0 during D3 of a frame.
   - `tx` = 1 on the next edge; no `tx_done`.
   - After release, `tx_ready` = 1 and `tx` stays high.
6. Loopback into `uart_rx` with bytes 0x00, 0xFF, 0x5A, 0x81 → `rx_data_ready` with matching `data_out` for each. With `UART_TX_PARITY_EN` undefined, the frame is 160 cycles.
